pipelined_carry_chain_adder: RTL and testbench

Parametrised, pipelined successor to the fixed 39-bit CARRY4 final adder used in the approximate signed multipliers. It resolves the propagate/generate vectors from the partial-product compressor into the product's upper bits. The carry chain is cut into registered segments so wide multipliers (32×32 and up) close timing. It also carries an optional per-transaction approximate low region, selected at run time.

---
 rtl/pcca_pkg.sv | 23 ++
 rtl/carry_seg.sv | 58 +++++
 rtl/pipelined_carry_chain_adder.sv | 136 +++++++++++++
 tb/tb_pipelined_carry_chain_adder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcca_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pcca_pkg : shared helpers for pipelined_carry_chain_adder              |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package pcca_pkg;

   localparam int CARRY4_BITS = 4;

   function automatic int nseg(input int width, input int seg);
      return (seg > 0) ? width / seg : 1;
   endfunction

   // SEG must be checked before it is used as a divisor.
   function automatic bit params_legal(input int width, input int seg, input int apx_bits);
      if (seg <= 0 || width < 8) return 1'b0;
      return (width % CARRY4_BITS == 0) && (seg % CARRY4_BITS == 0) &&
             (width % seg == 0) && (apx_bits % CARRY4_BITS == 0) &&
             (apx_bits >= 0) && (apx_bits <= seg);
   endfunction

endpackage
`default_nettype wire

// File: rtl/carry_seg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | carry_seg : combinational SEG-bit carry chain with approximate mask    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module carry_seg
   import pcca_pkg::*;
#(
   parameter int SEG = 8
)(
   input  logic [SEG-1:0] prop,
   input  logic [SEG-1:0] gen,
   input  logic           ci,
   input  logic [SEG-1:0] apx_mask,
   output logic [SEG-1:0] s,
   output logic           co
);

`ifdef PCCA_XILINX_CARRY4
   // Masked bits force the mux to select gen, so the carry leaving the region is gen[top].
   logic [SEG/CARRY4_BITS:0] chain;
   logic [SEG-1:0]           prop_eff;
   logic [SEG-1:0]           s_chain;

   assign prop_eff = prop & ~apx_mask;
   assign chain[0] = ci;

   for (genvar q = 0; q < SEG/CARRY4_BITS; q++) begin : g_carry4
      logic [3:0] co4;
      CARRY4 u_carry4 (
         .CO     (co4),
         .O      (s_chain[4*q +: 4]),
         .CI     (chain[q]),
         .CYINIT (1'b0),
         .DI     (gen[4*q +: 4]),
         .S      (prop_eff[4*q +: 4])
      );
      assign chain[q+1] = co4[3];
   end

   assign s  = (apx_mask & prop) | (~apx_mask & s_chain);
   assign co = chain[SEG/CARRY4_BITS];
`else
   logic c_walk;

   always_comb begin
      s      = '0;
      c_walk = ci;
      for (int i = 0; i < SEG; i++) begin
         s[i]   = apx_mask[i] ? prop[i] : (prop[i] ^ c_walk);
         c_walk = (prop[i] && !apx_mask[i]) ? c_walk : gen[i];
      end
      co = c_walk;
   end
`endif

endmodule
`default_nettype wire

// File: rtl/pipelined_carry_chain_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipelined_carry_chain_adder : segmented, registered prop/gen resolver  |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module pipelined_carry_chain_adder
   import pcca_pkg::*;
#(
   parameter int WIDTH    = 40,
   parameter int SEG      = 8,
   parameter int APX_BITS = 0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] prop,
   input  logic [WIDTH-1:0] gen,
   input  logic             cin,
   input  logic             apx_en,
   output logic             out_valid,
   output logic [WIDTH:0]   sum
);

   localparam int             NSEG     = nseg(WIDTH, SEG);
   localparam logic [SEG-1:0] APX_MASK = ~({SEG{1'b1}} << APX_BITS);

   if (!params_legal(WIDTH, SEG, APX_BITS)) begin : g_bad_params
      $fatal(1, "pipelined_carry_chain_adder: illegal WIDTH/SEG/APX_BITS combination");
   end

   logic [NSEG-1:0]           valid_d, valid_q;
   logic                      apx_d, apx_q;
   logic                      cin_d, cin_q;
   logic                      out_valid_d, out_valid_q;
   logic [WIDTH:0]            sum_d, sum_q;
   logic [NSEG-1:0][SEG-1:0]  seg_s;
   logic [NSEG-1:0][SEG-1:0]  sum_slice;
   logic [NSEG-1:0]           seg_co;

   always_comb begin
      valid_d    = '0;
      valid_d[0] = in_valid;
      for (int k = 1; k < NSEG; k++) valid_d[k] = valid_q[k-1];
      apx_d       = apx_en;
      cin_d       = cin;
      out_valid_d = valid_q[NSEG-1];
      // An empty slot leaves the previous result on the output.
      sum_d       = valid_q[NSEG-1] ? {seg_co[NSEG-1], sum_slice} : sum_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= '0;
         apx_q       <= 1'b0;
         cin_q       <= 1'b0;
         out_valid_q <= 1'b0;
         sum_q       <= '0;
      end else if (ce) begin
         valid_q     <= valid_d;
         apx_q       <= apx_d;
         cin_q       <= cin_d;
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;

   for (genvar k = 0; k < NSEG; k++) begin : g_seg
      // Entry k+1 deep: input capture plus k skew stages; {gen, prop} per slot.
      logic [2*SEG-1:0] pg_d [k+1];
      logic [2*SEG-1:0] pg_q [k+1];
      logic             seg_ci;
      logic [SEG-1:0]   seg_mask;

      always_comb begin
         pg_d[0] = {gen[k*SEG +: SEG], prop[k*SEG +: SEG]};
         for (int j = 1; j <= k; j++) pg_d[j] = pg_q[j-1];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst)     pg_q <= '{default: '0};
         else if (ce) pg_q <= pg_d;
      end

      if (k == 0) begin : g_head
         assign seg_ci   = cin_q;
         assign seg_mask = apx_q ? APX_MASK : '0;
      end else begin : g_body
         logic carry_d, carry_q;

         always_comb carry_d = seg_co[k-1];

         always_ff @(posedge clk or posedge rst) begin
            if (rst)     carry_q <= 1'b0;
            else if (ce) carry_q <= carry_d;
         end

         assign seg_ci   = carry_q;
         assign seg_mask = '0;
      end

      carry_seg #(.SEG(SEG)) u_carry_seg (
         .prop     (pg_q[k][SEG-1:0]),
         .gen      (pg_q[k][2*SEG-1:SEG]),
         .ci       (seg_ci),
         .apx_mask (seg_mask),
         .s        (seg_s[k]),
         .co       (seg_co[k])
      );

      if (k == NSEG-1) begin : g_no_deskew
         assign sum_slice[k] = seg_s[k];
      end else begin : g_deskew
         localparam int DEPTH = NSEG-1-k;
         logic [SEG-1:0] dsk_d [DEPTH];
         logic [SEG-1:0] dsk_q [DEPTH];

         always_comb begin
            dsk_d[0] = seg_s[k];
            for (int j = 1; j < DEPTH; j++) dsk_d[j] = dsk_q[j-1];
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst)     dsk_q <= '{default: '0};
            else if (ce) dsk_q <= dsk_d;
         end

         assign sum_slice[k] = dsk_q[DEPTH-1];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_carry_chain_adder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pipelined_carry_chain_adder : scoreboard bench, 40/8/8 and 8/8/0    |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_pipelined_carry_chain_adder;

   localparam int         W    = 40;
   localparam int         S    = 8;
   localparam int         A    = 8;
   localparam int         LAT  = W / S;
   localparam logic [W:0] ZERO = '0;
   localparam logic [W:0] ONE  = 1;

   logic         clk      = 1'b0;
   logic         rst      = 1'b1;
   logic         ce       = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] prop     = '0;
   logic [W-1:0] gen      = '0;
   logic         cin      = 1'b0;
   logic         apx_en   = 1'b0;
   logic         out_valid;
   logic [W:0]   sum;

   logic         in_valid8 = 1'b0;
   logic [7:0]   prop8     = '0;
   logic [7:0]   gen8      = '0;
   logic         cin8      = 1'b0;
   logic         apx8      = 1'b0;
   logic         out_valid8;
   logic [8:0]   sum8;

   int             checks = 0;
   int             errors = 0;
   int             n_in   = 0;
   int             n_out  = 0;
   logic [W:0]     sb [$];
   logic [W:0]     cur_exp   = '0;
   logic [W:0]     model_sum = '0;
   logic [LAT-1:0] vpipe     = '0;
   logic           exp_ov    = 1'b0;
   logic           adv_edge  = 1'b0;
   logic [W-1:0]   ra, rb;
   int             base;

   always #5 clk = ~clk;

   pipelined_carry_chain_adder #(.WIDTH(W), .SEG(S), .APX_BITS(A)) dut (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .prop(prop), .gen(gen),
      .cin(cin), .apx_en(apx_en), .out_valid(out_valid), .sum(sum)
   );

   pipelined_carry_chain_adder #(.WIDTH(8), .SEG(8), .APX_BITS(0)) dut8 (
      .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid8), .prop(prop8), .gen(gen8),
      .cin(cin8), .apx_en(apx8), .out_valid(out_valid8), .sum(sum8)
   );

   // Arithmetic reference: exact a+b+cin, or pass-through low A bits with gen[A-1] as carry.
   function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic apx);
      logic [W-A:0] hi;
      if (!apx) return (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
      hi = (W-A+1)'(a[W-1:A]) + (W-A+1)'(b[W-1:A]) + (W-A+1)'(a[A-1]);
      return {hi, a[A-1:0] ^ b[A-1:0]};
   endfunction

   task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      check(tag, (W+1)'(obs), (W+1)'(exp));
   endtask

   task automatic put(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic apx);
      in_valid = v;
      prop     = a ^ b;
      gen      = a;
      cin      = c;
      apx_en   = apx;
      cur_exp  = ref_sum(a, b, c, apx);
   endtask

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic apx);
      @(negedge clk);
      put(1'b1, a, b, c, apx);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Capture side: push expected results and model the valid latency.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         vpipe    <= '0;
         exp_ov   <= 1'b0;
         adv_edge <= 1'b0;
         n_in     <= 0;
      end else begin
         adv_edge <= ce;
         if (ce) begin
            exp_ov <= vpipe[LAT-1];
            vpipe  <= {vpipe[LAT-2:0], in_valid};
            if (in_valid) begin
               sb.push_back(cur_exp);
               n_in <= n_in + 1;
            end
         end
      end
   end

   // Output side, sampled half a cycle after the active edge.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         model_sum <= '0;
         n_out     <= 0;
      end else begin
         check1("out_valid", out_valid, exp_ov);
         if (adv_edge && out_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL unexpected_result observed=%0h expected=none", sum);
            end else begin
               check("sum", sum, sb[0]);
               model_sum <= sb[0];
               void'(sb.pop_front());
               n_out <= n_out + 1;
            end
         end else begin
            check("sum_hold", sum, model_sum);
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      check1("rst_out_valid", out_valid, 1'b0);
      check("rst_sum", sum, ZERO);
      check1("rst_out_valid8", out_valid8, 1'b0);
      check("rst_sum8", (W+1)'(sum8), ZERO);
      #2 rst = 1'b0;
      ce = 1'b1;

      // Full ripple through every segment.
      drive('0, '1, 1'b1, 1'b0);
      idle();
      repeat (4) @(negedge clk);
      check1("ripple_not_early", out_valid, 1'b0);
      @(negedge clk);
      check1("ripple_valid", out_valid, 1'b1);
      check("ripple_sum", sum, 41'h100_0000_0000);
      @(negedge clk);
      check1("ripple_one_cycle", out_valid, 1'b0);

      // Exact and approximate back to back; cin must be ignored in approximate mode.
      drive(40'h12_3456_789A, 40'h0F_EDCB_A987, 1'b0, 1'b0);
      drive(40'h12_3456_789A, 40'h0F_EDCB_A987, 1'b0, 1'b1);
      drive(40'h12_3456_789A, 40'h0F_EDCB_A987, 1'b0, 1'b0);
      drive(40'h12_3456_789A, 40'h0F_EDCB_A987, 1'b1, 1'b1);
      idle();
      repeat (2) @(negedge clk);
      check("exact_sum", sum, 41'h22_2222_2221);
      @(negedge clk);
      check("apx_sum", sum, 41'h22_2222_221D);
      @(negedge clk);
      check("exact_after_apx", sum, 41'h22_2222_2221);
      @(negedge clk);
      check("apx_cin_ignored", sum, 41'h22_2222_221D);

      // Degenerate single-segment build: one cycle of latency.
      @(negedge clk);
      in_valid8 = 1'b1; prop8 = 8'hFE; gen8 = 8'hFF; cin8 = 1'b0; apx8 = 1'b0;
      @(negedge clk);
      in_valid8 = 1'b0;
      check1("deg_not_early", out_valid8, 1'b0);
      @(negedge clk);
      check1("deg_valid", out_valid8, 1'b1);
      check("deg_sum", (W+1)'(sum8), (W+1)'(9'h100));

      // Random stream with ce gaps and mixed modes.
      base = n_in;
      for (int cyc = 0; cyc < 4000 && (n_in - base) < 200; cyc++) begin
         @(negedge clk);
         ce = ($urandom_range(0, 3) != 0);
         ra = {8'($urandom), $urandom};
         rb = {8'($urandom), $urandom};
         put(($urandom_range(0, 5) != 0), ra, rb, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      end
      check1("stream_captured_200", ((n_in - base) >= 200), 1'b1);
      @(negedge clk);
      ce = 1'b1;
      in_valid = 1'b0;
      repeat (LAT + 2) @(negedge clk);
      check("stream_count", (W+1)'(n_out), (W+1)'(n_in));
      check("stream_drained", (W+1)'(sb.size()), ZERO);

      // Asynchronous reset two cycles after three captures.
      for (int t = 0; t < 3; t++) drive({8'($urandom), $urandom}, {8'($urandom), $urandom}, 1'b0, 1'b0);
      idle();
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check1("async_rst_out_valid", out_valid, 1'b0);
      check("async_rst_sum", sum, ZERO);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (LAT + 6) @(negedge clk);
      check("no_stale_result", (W+1)'(n_out), ZERO);
      check("sum_stays_zero", sum, ZERO);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
